// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if
//   Bundles every signal the fetch unit exchanges with its neighbours:
//   instruction memory (request/response), the redirect source and the
//   decode stage.
//
//   Signal summary (direction as seen from the fetch unit, modport master):
//     imem_req_valid   out  1   fetch request to instruction memory
//     imem_req_addr    out  32  word-aligned byte address of the request
//     imem_req_ready   in   1   memory accepts the request this cycle
//     imem_resp_valid  in   1   response data valid this cycle
//     imem_resp_data   in   32  fetched instruction word
//     redirect_valid   in   1   taken branch/jump, refetch from redirect_pc
//     redirect_pc      in   32  redirect target address
//     id_ready         in   1   decode consumes the output slot this cycle
//     if_valid         out  1   output slot holds a valid instruction
//     if_instr         out  32  instruction in the output slot
//     if_pc            out  32  address of if_instr
//     if_opcode        out  7   if_instr[6:0] for the control unit
//
//   The slave modport is the mirror image, used by the environment.
// ----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [6:0]  if_opcode;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  redirect_valid,
        input  redirect_pc,
        input  id_ready,
        output if_valid,
        output if_instr,
        output if_pc,
        output if_opcode
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        output redirect_valid,
        output redirect_pc,
        output id_ready,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        input  if_opcode
    );
endinterface

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Keeps a pc register, issues at most one
//   instruction-memory request at a time, and places each returned word in a
//   one-entry output slot for the decode stage. Redirects flush the slot and
//   restart fetching at the (word-aligned) target; a response belonging to a
//   request issued before a redirect is dropped via the discard flag.
//
//   Ports:
//     clk   in   sole clock, rising edge
//     rst   in   synchronous, active-high reset
//     bus   fetch_unit_if.master -- memory, redirect and decode signals
//
//   Parameter:
//     RESET_PC   first fetch address after reset (must be word aligned)
//
//   FSM states:
//     state  | meaning
//     -------+------------------------------------------------------------
//     S_REQ  | no request outstanding; present pc to memory when the slot
//            | is empty or being drained this cycle
//     S_WAIT | one request outstanding; waiting for imem_resp_valid
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;

    logic        req_valid;
    logic        req_fire;
    logic        resp_take;

    // A new request is only allowed when the slot will have room for its
    // response: either it is empty or decode drains it this very cycle.
    assign req_valid = (state_q == S_REQ) && (!if_valid_q || bus.id_ready);
    assign req_fire  = req_valid && bus.imem_req_ready;

    // Responses are only meaningful while a request is outstanding.
    assign resp_take = (state_q == S_WAIT) && bus.imem_resp_valid;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.if_valid       = if_valid_q;
    assign bus.if_instr       = if_instr_q;
    assign bus.if_pc          = if_pc_q;
    assign bus.if_opcode      = if_instr_q[6:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            discard_q  <= 1'b0;
            if_valid_q <= 1'b0;
            if_instr_q <= 32'h0000_0000;
            if_pc_q    <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;

        if (bus.redirect_valid) begin
            // Redirect wins over everything else this cycle. The slot is
            // flushed even if decode is stalled; if_instr/if_pc keep their
            // stale values and are qualified by if_valid downstream.
            pc_d       = bus.redirect_pc & 32'hFFFF_FFFC;
            if_valid_d = 1'b0;
            case (state_q)
                S_REQ: begin
                    // A request handshaking now fetches the old path, so
                    // its response must be thrown away.
                    if (req_fire) begin
                        state_d   = S_WAIT;
                        discard_d = 1'b1;
                    end else begin
                        discard_d = 1'b0;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            if (if_valid_q && bus.id_ready) begin
                if_valid_d = 1'b0;
            end

            case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (resp_take) begin
                        state_d = S_REQ;
                        if (discard_q) begin
                            discard_d = 1'b0;
                        end else begin
                            // The request was only issued with room in the
                            // slot, so loading here never overwrites an
                            // unconsumed instruction.
                            if_valid_d = 1'b1;
                            if_instr_d = bus.imem_resp_data;
                            if_pc_d    = pc_q;
                            pc_d       = pc_q + 32'd4;
                        end
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset (bits [1:0] SHALL be 00).
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 imem_req_addr  output  32  byte address of the request (word aligned).
REQ-006 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 imem_resp_valid  input  1  response data valid this cycle.
REQ-008 imem_resp_data  input  32  fetched instruction word.
REQ-009 redirect_valid  input  1  branch/jump taken; refetch from redirect_pc.
REQ-010 redirect_pc  input  32  redirect target address.
REQ-011 id_ready  input  1  decode stage consumes the output slot this cycle.
REQ-012 if_valid  output  1  output slot holds a valid instruction.
REQ-013 if_instr  output  32  instruction in the output slot.
REQ-014 if_pc  output  32  address of if_instr.
REQ-015 if_opcode  output  7  if_instr[6:0], combinational, drives the control unit opcode input.

Function
REQ-016 The block SHALL hold a 32-bit pc register, a 2-state FSM {REQ, WAIT}, a discard flag and a one-entry output slot (if_valid/if_instr/if_pc).
REQ-017 At most one memory request SHALL be outstanding at any time.
REQ-018 imem_req_valid SHALL equal (state==REQ) && (!if_valid || id_ready); imem_req_addr SHALL equal pc whenever imem_req_valid is 1.
REQ-019 REQ -> WAIT when imem_req_valid && imem_req_ready; otherwise remain in REQ.
REQ-020 In WAIT with imem_resp_valid and discard==0: slot loads (if_valid=1, if_instr=imem_resp_data, if_pc=pc), pc <= pc+4, FSM -> REQ.
REQ-021 In WAIT with imem_resp_valid and discard==1: response dropped, discard cleared, pc unchanged, FSM -> REQ.
REQ-022 imem_resp_valid in state REQ SHALL be ignored with no state change.
REQ-023 Latency: response in cycle M SHALL appear as if_valid=1 in cycle M+1; with single-cycle memory and id_ready held high, the block SHALL sustain one instruction every 2 cycles.
REQ-024 The slot SHALL clear (if_valid=0) when if_valid && id_ready and no new response loads it in the same cycle; with id_ready=0 the slot contents SHALL hold unchanged.
REQ-025 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-026 redirect_valid SHALL take priority over every other event in its cycle: pc <= {redirect_pc[31:2],2'b00}, if_valid <= 0 (flush, irrespective of id_ready).
REQ-027 Redirect while state==WAIT without imem_resp_valid: discard <= 1, FSM stays WAIT.
REQ-028 Redirect while state==WAIT with imem_resp_valid: response dropped, discard <= 0, FSM -> REQ.
REQ-029 Redirect while state==REQ and request handshake occurs in the same cycle: discard <= 1, FSM -> WAIT (old-address response will be dropped).
REQ-030 Redirect while state==REQ without handshake: FSM stays REQ; next request uses the new pc.
REQ-031 if_instr and if_pc SHALL retain their last values when if_valid falls; consumers SHALL qualify them with if_valid.

Reset
REQ-032 On rst=1 at a rising edge: pc=RESET_PC, state=REQ, discard=0, if_valid=0, if_instr=32'h0, if_pc=32'h0; rst SHALL override redirect and responses in that cycle.
REQ-033 Reset mid-transaction SHALL abandon the outstanding request; the memory is reset by the same rst, so no stale response is expected.
REQ-034 First request (imem_req_valid=1, addr=RESET_PC) SHALL be presented in the first cycle after rst deasserts.

Verification
REQ-035 Straight-line fetch: RESET_PC=0, 1-cycle memory returning 32'h00000013, id_ready=1 -> if_pc sequence 0x0,0x4,0x8 with if_valid pulses every 2 cycles, if_opcode=7'h13.
REQ-036 Back-pressure: id_ready=0 with slot valid (if_pc=0x4) -> imem_req_valid=0, slot holds 0x4 for all stalled cycles; id_ready=1 -> request for 0x8 issued the same cycle.
REQ-037 Redirect during WAIT: request for 0x8 outstanding, redirect_pc=0x100 -> response for 0x8 dropped, next request addr=0x100, next if_pc=0x100.
REQ-038 Redirect coincident with handshake and with response: each case -> no instruction from the old path ever reaches if_valid=1; redirect_pc=0x203 -> fetch addr 0x200.
REQ-039 Wrap: redirect_pc=32'hFFFF_FFFC -> if_pc 0xFFFF_FFFC followed by 0x0000_0000.
REQ-040 Reset mid-WAIT with slot valid -> next cycle if_valid=0, imem_req_valid=1, imem_req_addr=RESET_PC.
